// File: rtl/load_store_unit_if.sv
// Core/memory handshake bundle for the load/store unit.
// slave = the LSU itself; master = the core + data memory environment.
interface load_store_unit_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  // data memory port
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // completion
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;

  modport slave (
    input  req_valid, is_store, funct3, addr, store_data,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output resp_valid, resp_data, resp_fault
  );

  modport master (
    output req_valid, is_store, funct3, addr, store_data,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, valid/ready memory port,
// store lane replication, load alignment/extension, fault detection.
// Every output is either a register or a decode of the state register.
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Decode fault on the incoming request (only used on the accept edge).
  always_comb begin
    illegal = 1'b0;
    if (bus.is_store) illegal = (bus.funct3 > 3'b010);
    else              illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
    misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
  end

  // Shift the addressed byte/half down to bit 0 and extend per registered funct3.
  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state and next-register logic; everything holds unless changed.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_we_d     = mem_we_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d    = bus.funct3;
          off_d       = bus.addr[1:0];
          resp_data_d = 32'b0;
          if (illegal || misaligned) begin
            // no memory access; answer straight away
            resp_fault_d = 1'b1;
            state_d      = RESP;
          end else begin
            mem_addr_d = {bus.addr[31:2], 2'b00};
            mem_we_d   = bus.is_store;
            if (bus.is_store) begin
              case (bus.funct3[1:0])
                2'b00: begin
                  mem_wdata_d = {4{bus.store_data[7:0]}};
                  mem_wstrb_d = 4'b0001 << bus.addr[1:0];
                end
                2'b01: begin
                  mem_wdata_d = {2{bus.store_data[15:0]}};
                  mem_wstrb_d = bus.addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  mem_wdata_d = bus.store_data;
                  mem_wstrb_d = 4'b1111;
                end
              endcase
            end else begin
              mem_wdata_d = 32'b0;
              mem_wstrb_d = 4'b0000;
            end
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_ready) state_d = mem_we_q ? RESP : WAIT_R;
      end
      WAIT_R: begin
        if (bus.mem_rvalid) begin
          resp_data_d = load_ext;
          state_d     = RESP;
        end
      end
      RESP: begin
        // response fields are only meaningful during the pulse
        resp_data_d  = 32'b0;
        resp_fault_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
      mem_wstrb_q  <= 4'b0;
      mem_we_q     <= 1'b0;
      resp_data_q  <= 32'b0;
      resp_fault_q <= 1'b0;
      funct3_q     <= 3'b0;
      off_q        <= 2'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_we_q     <= mem_we_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_valid  = (state_q == REQ);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, store lanes with stalls,
// load extension, latency, stray rvalid, faults, back-to-back issue.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE against a zero-wait memory; report the
  // response, cycles from accept to resp_valid, and whether mem_valid was seen.
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         output logic [31:0] d, output logic f, output int lat,
                         output logic saw_mv);
    bus.req_valid  = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    saw_mv = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      saw_mv = saw_mv | bus.mem_valid;
      @(posedge clk); #1;
      lat++;
    end
    d = bus.resp_data;
    f = bus.resp_fault;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic seen;
    #2;
    tests++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_we, bus.resp_valid, bus.resp_fault} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl got %b want 10000",
        {bus.req_ready, bus.mem_valid, bus.mem_we, bus.resp_valid, bus.resp_fault});
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata, bus.resp_data, bus.mem_wstrb} !== 100'b0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%b want zeros",
        bus.mem_addr, bus.mem_wdata, bus.resp_data, bus.mem_wstrb);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // start a store that stalls in REQ, then reset it
    bus.req_valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h10; bus.store_data = 32'h55; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    tests++;
    if (bus.mem_valid !== 1'b1) begin
      fails++; $display("FAIL rst_pre_mem_valid got %b want 1", bus.mem_valid);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({bus.mem_valid, bus.req_ready, bus.resp_valid} !== 3'b010) begin
      fails++; $display("FAIL rst_abort got %b want 010", {bus.mem_valid, bus.req_ready, bus.resp_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | bus.resp_valid | bus.mem_valid | !bus.req_ready;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rst_no_resp got activity=%b want 0", seen);
    end
  endtask

  task automatic test_sb_stall();
    bus.req_valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000;
    bus.addr = 32'h1003; bus.store_data = 32'hAABBCCDD; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_valid}
          !== {1'b1, 1'b1, 32'h1000, 32'hDDDDDDDD, 4'b1000, 1'b0}) begin
        fails++; $display("FAIL sb_req cyc%0d got v=%b we=%b a=%h d=%h s=%b r=%b want 1 1 1000 DDDDDDDD 1000 0",
          i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_valid);
      end
      if (i == 2) bus.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    tests++;
    if ({bus.resp_valid, bus.resp_fault, bus.resp_data, bus.mem_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL sb_resp got rv=%b f=%b d=%h mv=%b want 1 0 0 0",
        bus.resp_valid, bus.resp_fault, bus.resp_data, bus.mem_valid);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      fails++; $display("FAIL sb_single_pulse got rv=%b rr=%b want 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] d; logic f; int lat; logic mv;
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000};
    logic [31:0] as  [6] = '{32'h2001, 32'h2001, 32'h2002, 32'h2000, 32'h2000, 32'h2003};
    logic [31:0] exp [6] = '{32'hFFFFFFF6, 32'h000000F6, 32'h00001234, 32'h0000F678, 32'hFFFFF678, 32'h00000012};
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, f3s[i], as[i], 32'h0, 32'h1234F678, d, f, lat, mv);
      tests++;
      if ({d, f, lat} !== {exp[i], 1'b0, 32'd3}) begin
        fails++; $display("FAIL load_ext[%0d] got d=%h f=%b lat=%0d want %h 0 3", i, d, f, lat, exp[i]);
      end
    end
  endtask

  task automatic test_lw_stray();
    logic [31:0] d; logic f; int lat; logic mv;
    run_req(1'b0, 3'b010, 32'h4000, 32'h0, 32'hDEADBEEF, d, f, lat, mv);
    tests++;
    if ({d, f, lat} !== {32'hDEADBEEF, 1'b0, 32'd3}) begin
      fails++; $display("FAIL lw_zero_wait got d=%h f=%b lat=%0d want DEADBEEF 0 3", d, f, lat);
    end
    // stray rvalid while idle
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    tests++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      fails++; $display("FAIL stray_idle got rr=%b rv=%b want 1 0", bus.req_ready, bus.resp_valid);
    end
    // LW with memory stalled in REQ while a stray rvalid arrives
    bus.req_valid = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h4008;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h22222222;
    @(posedge clk); #1;
    tests++;
    if ({bus.mem_valid, bus.resp_valid} !== 2'b10) begin
      fails++; $display("FAIL stray_req got mv=%b rv=%b want 1 0", bus.mem_valid, bus.resp_valid);
    end
    bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({bus.mem_valid, bus.resp_valid, bus.req_ready} !== 3'b000) begin
      fails++; $display("FAIL wait_r_hold got mv=%b rv=%b rr=%b want 0 0 0",
        bus.mem_valid, bus.resp_valid, bus.req_ready);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h33333333;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    tests++;
    if ({bus.resp_valid, bus.resp_data} !== {1'b1, 32'h33333333}) begin
      fails++; $display("FAIL stray_lw_data got rv=%b d=%h want 1 33333333", bus.resp_valid, bus.resp_data);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus.resp_valid, bus.resp_data} !== {1'b0, 32'h0}) begin
      fails++; $display("FAIL resp_clear got rv=%b d=%h want 0 00000000", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_fault();
    logic [31:0] d; logic f; int lat; logic mv;
    logic        sts [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'b001, 3'b011, 3'b010, 3'b011, 3'b001};
    logic [31:0] as  [5] = '{32'h3001, 32'h3000, 32'h3002, 32'h3000, 32'h3003};
    for (int i = 0; i < 5; i++) begin
      run_req(sts[i], f3s[i], as[i], 32'hFFFFFFFF, 32'hFFFFFFFF, d, f, lat, mv);
      tests++;
      if ({f, d, lat, mv} !== {1'b1, 32'h0, 32'd1, 1'b0}) begin
        fails++; $display("FAIL fault[%0d] got f=%b d=%h lat=%0d mv=%b want 1 0 1 0", i, f, d, lat, mv);
      end
      tests++;
      if (bus.resp_fault !== 1'b0) begin
        fails++; $display("FAIL fault_clear[%0d] got %b want 0", i, bus.resp_fault);
      end
    end
    // legal store: two cycles to response, memory touched
    run_req(1'b1, 3'b010, 32'h3004, 32'h12345678, 32'h0, d, f, lat, mv);
    tests++;
    if ({f, d, lat, mv} !== {1'b0, 32'h0, 32'd2, 1'b1}) begin
      fails++; $display("FAIL sw_latency got f=%b d=%h lat=%0d mv=%b want 0 0 2 1", f, d, lat, mv);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n = 0, acc1 = -1, acc2 = -1, rsp_n = 0, rsp1 = -1, rsp2 = -1, mh_n = 0;
    logic [31:0] rsp2_data = '0, mh1_wdata = '0, mh2_addr = '0;
    logic mh1_we = 1'b0, mh2_we = 1'b1, acc;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADBEEF;
    bus.req_valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h5000; bus.store_data = 32'hCAFEF00D;
    for (int c = 0; c < 10; c++) begin
      if (bus.resp_valid) begin
        rsp_n++;
        if (rsp_n == 1) rsp1 = c;
        else begin rsp2 = c; rsp2_data = bus.resp_data; end
      end
      if (bus.mem_valid && bus.mem_ready) begin
        mh_n++;
        if (mh_n == 1) begin mh1_we = bus.mem_we; mh1_wdata = bus.mem_wdata; end
        else begin mh2_we = bus.mem_we; mh2_addr = bus.mem_addr; end
      end
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_n++;
        if (acc_n == 1) begin
          acc1 = c;
          bus.is_store = 1'b0; bus.addr = 32'h5004; bus.store_data = 32'h0;
        end else begin
          acc2 = c;
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    tests++;
    if ({acc_n, acc1, acc2} !== {32'd2, 32'd0, 32'd3}) begin
      fails++; $display("FAIL b2b_accepts got n=%0d at %0d,%0d want 2 at 0,3", acc_n, acc1, acc2);
    end
    tests++;
    if ({rsp_n, rsp1, rsp2} !== {32'd2, 32'd2, 32'd6}) begin
      fails++; $display("FAIL b2b_resps got n=%0d at %0d,%0d want 2 at 2,6", rsp_n, rsp1, rsp2);
    end
    tests++;
    if ({mh_n, mh1_we, mh1_wdata, mh2_we, mh2_addr, rsp2_data}
        !== {32'd2, 1'b1, 32'hCAFEF00D, 1'b0, 32'h5004, 32'h0BADBEEF}) begin
      fails++; $display("FAIL b2b_mem got n=%0d we1=%b wd1=%h we2=%b a2=%h rd=%h want 2 1 CAFEF00D 0 5004 0BADBEEF",
        mh_n, mh1_we, mh1_wdata, mh2_we, mh2_addr, rsp2_data);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b0;
    bus.addr = 32'h0; bus.store_data = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_sb_stall();
    test_load_extend();
    test_lw_stray();
    test_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
